// File: rtl/register_file.sv
// Two-read/one-write register file with hardwired-zero r0 and combinational reads.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] bank [DEPTH];
  logic                  write_en;

  assign write_en = reg_write && (write_reg != '0);

  // r0 has no storage; it is tied to zero so every read path sees 0.
  assign bank[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] value_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          value_reg <= '0;
        end else if (write_en && (write_reg == ADDR_WIDTH'(gi))) begin
          value_reg <= write_data;
        end
      end

      assign bank[gi] = value_reg;
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  logic hit1;
  logic hit2;

  assign hit1 = write_en && (write_reg == read_reg1);
  assign hit2 = write_en && (write_reg == read_reg2);

  always_comb begin
    read_data1 = bank[read_reg1];
    read_data2 = bank[read_reg2];
    if (hit1) read_data1 = write_data;
    if (hit2) read_data2 = write_data;
    // Reset forces zero even when a bypass hit would otherwise forward data.
    if (rst) begin
      read_data1 = '0;
      read_data2 = '0;
    end
  end
`else
  always_comb begin
    read_data1 = bank[read_reg1];
    read_data2 = bank[read_reg2];
    if (rst) begin
      read_data1 = '0;
      read_data2 = '0;
    end
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; expectations follow the build's
// REGFILE_BYPASS_EN setting.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int compared;
  int mismatched;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = addr;
    write_data = data;
    @(posedge clk);
    #1;
    reg_write  = 1'b0;
    $display("write r%0d <= %h", addr, data);
  endtask

  task automatic test_reset;
    read_reg1 = 5'd5;
    read_reg2 = 5'd31;
    #2;
    compared++;
    if (read_data1 !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_rd1: got %h expected %h", read_data1, 32'd0);
    end else $display("reset_rd1 ok");
    compared++;
    if (read_data2 !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_rd2: got %h expected %h", read_data2, 32'd0);
    end else $display("reset_rd2 ok");
    // a write request during reset must neither forward nor commit
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'h1111_1111;
    #1;
    compared++;
    if (read_data1 !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_no_bypass: got %h expected %h", read_data1, 32'd0);
    end else $display("reset_no_bypass ok");
    @(negedge clk);
    reg_write = 1'b0;
    rst = 1'b0;
    #1;
    compared++;
    if (read_data1 !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_held_write_lost: got %h expected %h", read_data1, 32'd0);
    end else $display("reset_held_write_lost ok");
  endtask

  task automatic test_async_clear;
    do_write(5'd5, 32'd34);
    do_write(5'd6, 32'd77);
    read_reg1 = 5'd5;
    read_reg2 = 5'd6;
    #1;
    compared++;
    if (read_data1 !== 32'd34) begin
      mismatched++;
      $display("FAIL clear_pre_r5: got %h expected %h", read_data1, 32'd34);
    end else $display("clear_pre_r5 ok");
    // assert reset between edges; clearing must not wait for the clock
    rst = 1'b1;
    #1;
    compared++;
    if (read_data1 !== 32'd0) begin
      mismatched++;
      $display("FAIL clear_async_r5: got %h expected %h", read_data1, 32'd0);
    end else $display("clear_async_r5 ok");
    #1;
    rst = 1'b0;
    #1;
    compared++;
    if (read_data1 !== 32'd0) begin
      mismatched++;
      $display("FAIL clear_after_r5: got %h expected %h", read_data1, 32'd0);
    end else $display("clear_after_r5 ok");
    compared++;
    if (read_data2 !== 32'd0) begin
      mismatched++;
      $display("FAIL clear_after_r6: got %h expected %h", read_data2, 32'd0);
    end else $display("clear_after_r6 ok");
  endtask

  task automatic test_basic;
    logic [31:0] mux_out;
    logic        alu_src;
    do_write(5'd8, 32'd34);
    do_write(5'd9, 32'd61);
    read_reg1 = 5'd8;
    read_reg2 = 5'd9;
    #1;
    compared++;
    if (read_data1 !== 32'd34) begin
      mismatched++;
      $display("FAIL basic_rd1: got %h expected %h", read_data1, 32'd34);
    end else $display("basic_rd1 ok");
    compared++;
    if (read_data2 !== 32'd61) begin
      mismatched++;
      $display("FAIL basic_rd2: got %h expected %h", read_data2, 32'd61);
    end else $display("basic_rd2 ok");
    alu_src = 1'b0;
    mux_out = alu_src ? 32'h0000_0004 : read_data2;
    compared++;
    if (mux_out !== 32'd61) begin
      mismatched++;
      $display("FAIL basic_alusrc_mux: got %h expected %h", mux_out, 32'd61);
    end else $display("basic_alusrc_mux ok");
    // swap addresses within the cycle; reads must follow immediately
    read_reg1 = 5'd9;
    read_reg2 = 5'd8;
    #1;
    compared++;
    if (read_data1 !== 32'd61 || read_data2 !== 32'd34) begin
      mismatched++;
      $display("FAIL basic_swap: got %h/%h expected %h/%h", read_data1, read_data2, 32'd61, 32'd34);
    end else $display("basic_swap ok");
  endtask

  task automatic test_zero;
    read_reg1 = 5'd0;
    read_reg2 = 5'd0;
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFF_FFFF;
    #1;
    compared++;
    if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
      mismatched++;
      $display("FAIL zero_bypass: got %h/%h expected %h/%h", read_data1, read_data2, 32'd0, 32'd0);
    end else $display("zero_bypass ok");
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    compared++;
    if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
      mismatched++;
      $display("FAIL zero_after: got %h/%h expected %h/%h", read_data1, read_data2, 32'd0, 32'd0);
    end else $display("zero_after ok");
  endtask

  task automatic test_same_addr;
    logic [31:0] exp_before;
`ifdef REGFILE_BYPASS_EN
    exp_before = 32'd99;
`else
    exp_before = 32'd7;
`endif
    do_write(5'd3, 32'd7);
    read_reg1 = 5'd9;
    read_reg2 = 5'd3;
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd3; write_data = 32'd99;
    #1;
    compared++;
    if (read_data2 !== exp_before) begin
      mismatched++;
      $display("FAIL same_before: got %h expected %h", read_data2, exp_before);
    end else $display("same_before ok");
    compared++;
    if (read_data1 !== 32'd61) begin
      mismatched++;
      $display("FAIL same_other_port: got %h expected %h", read_data1, 32'd61);
    end else $display("same_other_port ok");
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    compared++;
    if (read_data2 !== 32'd99) begin
      mismatched++;
      $display("FAIL same_after: got %h expected %h", read_data2, 32'd99);
    end else $display("same_after ok");
    // matching address without write enable must not forward
    write_data = 32'd5;
    #1;
    compared++;
    if (read_data2 !== 32'd99) begin
      mismatched++;
      $display("FAIL same_no_enable: got %h expected %h", read_data2, 32'd99);
    end else $display("same_no_enable ok");
  endtask

  task automatic test_write_disabled;
    do_write(5'd12, 32'h0000_ABCD);
    read_reg1 = 5'd12;
    @(negedge clk);
    reg_write = 1'b0; write_reg = 5'd12; write_data = 32'h0000_1234;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (read_data1 !== 32'h0000_ABCD) begin
      mismatched++;
      $display("FAIL write_disabled: got %h expected %h", read_data1, 32'h0000_ABCD);
    end else $display("write_disabled ok");
  endtask

  task automatic test_top_addr;
    do_write(5'd31, 32'hDEAD_BEEF);
    read_reg1 = 5'd31;
    read_reg2 = 5'd31;
    #1;
    compared++;
    if (read_data1 !== 32'hDEAD_BEEF || read_data2 !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL top_addr_both: got %h/%h expected %h", read_data1, read_data2, 32'hDEAD_BEEF);
    end else $display("top_addr_both ok");
    read_reg2 = 5'd30;
    #1;
    compared++;
    if (read_data2 !== 32'd0) begin
      mismatched++;
      $display("FAIL neighbour_untouched: got %h expected %h", read_data2, 32'd0);
    end else $display("neighbour_untouched ok");
  endtask

  task automatic test_reset_on_edge;
    read_reg1 = 5'd12;
    read_reg2 = 5'd4;
    @(negedge clk);
    rst = 1'b1;
    reg_write = 1'b1; write_reg = 5'd4; write_data = 32'd55;
    @(posedge clk);
    #1;
    compared++;
    if (read_data2 !== 32'd0) begin
      mismatched++;
      $display("FAIL rst_edge_during: got %h expected %h", read_data2, 32'd0);
    end else $display("rst_edge_during ok");
    @(negedge clk);
    rst = 1'b0;
    reg_write = 1'b0;
    #1;
    compared++;
    if (read_data2 !== 32'd0) begin
      mismatched++;
      $display("FAIL rst_edge_r4: got %h expected %h", read_data2, 32'd0);
    end else $display("rst_edge_r4 ok");
    compared++;
    if (read_data1 !== 32'd0) begin
      mismatched++;
      $display("FAIL rst_edge_r12: got %h expected %h", read_data1, 32'd0);
    end else $display("rst_edge_r12 ok");
    do_write(5'd4, 32'd55);
    compared++;
    if (read_data2 !== 32'd55) begin
      mismatched++;
      $display("FAIL rst_edge_rewrite: got %h expected %h", read_data2, 32'd55);
    end else $display("rst_edge_rewrite ok");
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    reg_write  = 1'b0;
    write_reg  = 5'd0;
    write_data = 32'd0;
    read_reg1  = 5'd0;
    read_reg2  = 5'd0;
    test_reset;
    test_async_clear;
    test_basic;
    test_zero;
    test_same_addr;
    test_write_disabled;
    test_top_addr;
    test_reset_on_edge;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
